// File: rtl/div_seq.sv
// div_seq: sequential restoring divider, unsigned DW-bit dividend by VW-bit
// divisor, one quotient bit per clock. Operands and results use valid/ready
// handshakes. Divide-by-zero is flagged and returns an all-ones quotient.
module div_seq #(
  parameter int DW = 8,
  parameter int VW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_valid,
  output logic          o_ready,
  input  logic [DW-1:0] i_dividend,
  input  logic [VW-1:0] i_divisor,
  output logic          o_valid,
  input  logic          i_ready,
  output logic [DW-1:0] o_quotient,
  output logic [VW-1:0] o_remainder,
  output logic          o_div_by_zero
);

  localparam int CW = (DW > 1) ? $clog2(DW) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_reg;
  logic [CW-1:0] cnt_reg;
  // Dividend bits shift out of the top while quotient bits shift in at the bottom.
  logic [DW-1:0] dvd_reg;
  logic [VW-1:0] dvs_reg;
  logic [VW-1:0] rem_reg;

  logic [VW:0]   rem_ext;
  logic          ge;
  logic [VW-1:0] diff;
  logic [VW-1:0] rem_next;
  logic [DW-1:0] dvd_next;

  // One restoring step: bring down the next dividend bit and trial-subtract.
  // The partial remainder is always below the divisor, so when the extended
  // remainder carries into bit VW the true difference still fits in VW bits
  // and the modular VW-bit subtraction gives it exactly.
  always_comb begin
    rem_ext  = {rem_reg, dvd_reg[DW-1]};
    diff     = rem_ext[VW-1:0] - dvs_reg;
    ge       = rem_ext[VW] || (rem_ext[VW-1:0] >= dvs_reg);
    rem_next = ge ? diff : rem_ext[VW-1:0];
    dvd_next = {dvd_reg[DW-2:0], ge};
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      cnt_reg       <= '0;
      dvd_reg       <= '0;
      dvs_reg       <= '0;
      rem_reg       <= '0;
      o_ready       <= 1'b0;
      o_valid       <= 1'b0;
      o_quotient    <= '0;
      o_remainder   <= '0;
      o_div_by_zero <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          o_valid <= 1'b0;
          if (i_valid && o_ready) begin
            o_ready <= 1'b0;
            dvd_reg <= i_dividend;
            dvs_reg <= i_divisor;
            rem_reg <= '0;
            if (i_divisor == '0) begin
              // Result is known now; o_valid follows one cycle later from DONE.
              state_reg     <= DONE;
              o_quotient    <= '1;
              o_remainder   <= '0;
              o_div_by_zero <= 1'b1;
            end else begin
              state_reg <= BUSY;
              cnt_reg   <= CW'(DW - 1);
            end
          end else begin
            o_ready <= 1'b1;
          end
        end

        BUSY: begin
          o_ready <= 1'b0;
          dvd_reg <= dvd_next;
          rem_reg <= rem_next;
          cnt_reg <= cnt_reg - CW'(1);
          if (cnt_reg == '0) begin
            state_reg     <= DONE;
            o_valid       <= 1'b1;
            o_quotient    <= dvd_next;
            o_remainder   <= rem_next;
            o_div_by_zero <= 1'b0;
          end
        end

        DONE: begin
          o_ready <= 1'b0;
          if (o_valid && i_ready) begin
            state_reg <= IDLE;
            o_valid   <= 1'b0;
            o_ready   <= 1'b1;
          end else begin
            // Covers the divide-by-zero path, which arrives with o_valid low.
            o_valid <= 1'b1;
          end
        end

        default: begin
          state_reg <= IDLE;
          o_valid   <= 1'b0;
          o_ready   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed checks of div_seq plus an exhaustive operand sweep.
module tb_div_seq;

  logic       clk;
  logic       rst_n;
  logic       i_valid;
  logic       o_ready;
  logic [7:0] i_dividend;
  logic [3:0] i_divisor;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_quotient;
  logic [3:0] o_remainder;
  logic       o_div_by_zero;

  int n_vec = 0;
  int n_err = 0;

  div_seq #(.DW(8), .VW(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_dividend   (i_dividend),
    .i_divisor    (i_divisor),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_quotient   (o_quotient),
    .o_remainder  (o_remainder),
    .o_div_by_zero(o_div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Submit one operation, measure latency from the accept edge, check result.
  // When i_ready is high the result is consumed and o_valid must drop.
  task automatic do_op(input logic [7:0] dvd, input logic [3:0] dvs,
                       input logic [7:0] eq, input logic [3:0] er,
                       input logic edz, input int elat);
    int guard;
    int lat;
    guard = 0;
    while (!o_ready && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    check("ready_before_accept", 32'(o_ready), 32'd1);
    i_valid    = 1'b1;
    i_dividend = dvd;
    i_divisor  = dvs;
    @(posedge clk); #1;
    i_valid = 1'b0;
    check("ready_low_after_accept", 32'(o_ready), 32'd0);
    lat = 0;
    while (!o_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(elat));
    check("quotient", 32'(o_quotient), 32'(eq));
    check("remainder", 32'(o_remainder), 32'(er));
    check("div_by_zero", 32'(o_div_by_zero), 32'(edz));
    $display("op %0d/%0d -> q=%0d r=%0d dz=%0b lat=%0d", dvd, dvs,
             o_quotient, o_remainder, o_div_by_zero, lat);
    if (i_ready) begin
      @(posedge clk); #1;
      check("valid_drop", 32'(o_valid), 32'd0);
      check("ready_after_handshake", 32'(o_ready), 32'd1);
    end
  endtask

  logic [7:0] hq;
  logic [3:0] hr;
  logic [7:0] hq0;
  logic [3:0] hr0;
  logic       hdz0;
  logic [7:0] bb_dvd [3];
  logic [3:0] bb_dvs [3];
  logic [7:0] bb_q   [3];
  logic [3:0] bb_r   [3];
  int         acc_cyc [3];
  int         idx_in;
  int         idx_out;
  logic       rdy_before;
  int         seen;

  initial begin
    rst_n      = 1'b0;
    i_valid    = 1'b0;
    i_dividend = 8'd0;
    i_divisor  = 4'd0;
    i_ready    = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_ready", 32'(o_ready), 32'd0);
    check("rst_quotient", 32'(o_quotient), 32'd0);
    check("rst_remainder", 32'(o_remainder), 32'd0);
    check("rst_dz", 32'(o_div_by_zero), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_after_release", 32'(o_ready), 32'd1);

    // Single op and boundaries
    do_op(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 8);
    do_op(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 8);
    do_op(8'd5, 4'd9, 8'd0, 4'd5, 1'b0, 8);
    do_op(8'd0, 4'd15, 8'd0, 4'd0, 1'b0, 8);
    do_op(8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 8);

    // Divide by zero, then a normal op clears the flag
    do_op(8'd100, 4'd0, 8'd255, 4'd0, 1'b1, 1);
    do_op(8'd10, 4'd3, 8'd3, 4'd1, 1'b0, 8);

    // Backpressure: result held for 5 cycles while new operands are offered
    i_ready = 1'b0;
    do_op(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 8);
    hq0  = o_quotient;
    hr0  = o_remainder;
    hdz0 = o_div_by_zero;
    i_valid    = 1'b1;
    i_dividend = 8'd50;
    i_divisor  = 4'd3;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check("bp_valid_held", 32'(o_valid), 32'd1);
      check("bp_ready_low", 32'(o_ready), 32'd0);
      check("bp_quotient_stable", 32'(o_quotient), 32'(hq0));
      check("bp_remainder_stable", 32'(o_remainder), 32'(hr0));
      check("bp_dz_stable", 32'(o_div_by_zero), 32'(hdz0));
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk); #1;
    check("bp_release_valid", 32'(o_valid), 32'd0);
    check("bp_release_quotient", 32'(o_quotient), 32'd28);

    // Back-to-back with i_valid held across three queued ops
    bb_dvd[0] = 8'd77;  bb_dvs[0] = 4'd5;  bb_q[0] = 8'd15; bb_r[0] = 4'd2;
    bb_dvd[1] = 8'd128; bb_dvs[1] = 4'd11; bb_q[1] = 8'd11; bb_r[1] = 4'd7;
    bb_dvd[2] = 8'd250; bb_dvs[2] = 4'd13; bb_q[2] = 8'd19; bb_r[2] = 4'd3;
    idx_in  = 0;
    idx_out = 0;
    i_valid    = 1'b1;
    i_dividend = bb_dvd[0];
    i_divisor  = bb_dvs[0];
    for (int c = 0; c < 100 && idx_out < 3; c++) begin
      rdy_before = o_ready;
      if (o_ready) check("bb_accept_only_idle", 32'(o_valid), 32'd0);
      @(posedge clk); #1;
      if (rdy_before && i_valid) begin
        acc_cyc[idx_in] = c;
        idx_in++;
        if (idx_in < 3) begin
          i_dividend = bb_dvd[idx_in];
          i_divisor  = bb_dvs[idx_in];
        end else begin
          i_valid = 1'b0;
        end
      end
      if (o_valid) begin
        check("bb_quotient", 32'(o_quotient), 32'(bb_q[idx_out]));
        check("bb_remainder", 32'(o_remainder), 32'(bb_r[idx_out]));
        $display("bb op %0d: %0d/%0d -> q=%0d r=%0d", idx_out, bb_dvd[idx_out],
                 bb_dvs[idx_out], o_quotient, o_remainder);
        idx_out++;
      end
    end
    i_valid = 1'b0;
    check("bb_results", 32'(idx_out), 32'd3);
    check("bb_accepts", 32'(idx_in), 32'd3);
    check("bb_spacing_01", 32'(acc_cyc[1] - acc_cyc[0]), 32'd10);
    check("bb_spacing_12", 32'(acc_cyc[2] - acc_cyc[1]), 32'd10);
    @(posedge clk); #1;

    // Reset in BUSY cycle 4 of 200/7
    i_valid    = 1'b1;
    i_dividend = 8'd200;
    i_divisor  = 4'd7;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(o_valid), 32'd0);
    check("midrst_ready", 32'(o_ready), 32'd0);
    check("midrst_quotient", 32'(o_quotient), 32'd0);
    check("midrst_remainder", 32'(o_remainder), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (o_valid) seen++;
    end
    check("midrst_no_result", 32'(seen), 32'd0);
    $display("reset mid-op: %0d stray results", seen);
    do_op(8'd9, 4'd2, 8'd4, 4'd1, 1'b0, 8);

    // Exhaustive sweep against / and %
    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          hq = 8'hFF;
          hr = 4'd0;
        end else begin
          hq = 8'(a / b);
          hr = 4'(a % b);
        end
        do_op(8'(a), 4'(b), hq, hr, (b == 0), (b == 0) ? 1 : 8);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
